// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the board.
// The master side is the sequencer itself; the slave side is the PLL,
// the downstream reset consumers and any supervisor issuing relock requests.
interface pll_reset_sequencer_if;
  logic       pll_locked;     // raw PLL lock, asynchronous to refclk
  logic       relock_req;     // single-cycle restart request
  logic       pll_rst;        // active-high PLL reset
  logic       sys_rst_n;      // active-low downstream reset
  logic       ready;          // sequencer in RUN
  logic       fault;          // sequencer in FAULT
  logic [2:0] state_o;        // current sequencer state
  logic [7:0] lock_loss_cnt;  // saturating count of lock losses while running

  modport master (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output fault,
    output state_o,
    output lock_loss_cnt
  );

  modport slave (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  fault,
    input  state_o,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, qualifies lock
// stability and only then releases the downstream reset. Runs entirely on the
// reference clock so it keeps working while the PLL outputs are dead.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                         refclk,
  input  logic                         rst,     // asynchronous, active low
  pll_reset_sequencer_if.master        seq_if
);

  // One shared timer serves all three timed states, so size it for the
  // longest interval. The timer only ever counts up to (interval - 1).
  localparam int TMAX_AB   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int TIMER_MAX = (TMAX_AB > LOCK_TIMEOUT_CYCLES) ? TMAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0] T_RST_LAST  = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_STAB_LAST = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_TO_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           retry_q, retry_d;
  logic [7:0]           loss_q,  loss_d;
  logic                 lk_meta_q, lk_q;
  logic                 restart_timer;

  // Two-flop synchronizer for the asynchronous PLL lock; lk_q is the only
  // lock view the FSM uses.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= seq_if.pll_locked;
      lk_q      <= lk_meta_q;
    end
  end

  // State, timer and counter registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RESET_PLL;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic. relock_req overrides everything; within a state, lock
  // status is examined before the timer so lock events win over timeouts.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    loss_d        = loss_q;
    restart_timer = 1'b0;

    if (seq_if.relock_req) begin
      // Also restarts the reset pulse when already in RESET_PLL.
      state_d       = S_RESET_PLL;
      retry_d       = '0;
      restart_timer = 1'b1;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (timer_q == T_RST_LAST) begin
            state_d       = S_WAIT_LOCK;
            restart_timer = 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (lk_q) begin
            state_d       = S_STABILIZE;
            restart_timer = 1'b1;
          end else if (timer_q == T_TO_LAST) begin
            restart_timer = 1'b1;
            if (retry_q == RETRY_LIMIT) begin
              state_d = S_FAULT;
            end else begin
              retry_d = retry_q + 8'd1;
              state_d = S_RESET_PLL;
            end
          end
        end

        S_STABILIZE: begin
          // Any dropout restarts qualification from scratch with a fresh
          // timeout window.
          if (!lk_q) begin
            state_d       = S_WAIT_LOCK;
            restart_timer = 1'b1;
          end else if (timer_q == T_STAB_LAST) begin
            state_d       = S_RUN;
            retry_d       = '0;
            restart_timer = 1'b1;
          end
        end

        S_RUN: begin
          if (!lk_q) begin
            state_d       = S_RESET_PLL;
            restart_timer = 1'b1;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 8'd1;
            end
          end
        end

        S_FAULT: begin
          // Parked until relock_req or reset; lock is ignored here.
        end

        default: begin
          state_d       = S_RESET_PLL;
          restart_timer = 1'b1;
        end
      endcase
    end
  end

  // Timer: cleared on every state entry, counts only in the timed states.
  // Each timed state leaves at its terminal count, so it never wraps.
  always_comb begin
    timer_d = timer_q;
    if (restart_timer) begin
      timer_d = '0;
    end else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK ||
                 state_q == S_STABILIZE) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Moore outputs decoded straight from the state register.
  assign seq_if.pll_rst       = (state_q == S_RESET_PLL);
  assign seq_if.sys_rst_n     = (state_q == S_RUN);
  assign seq_if.ready         = (state_q == S_RUN);
  assign seq_if.fault         = (state_q == S_FAULT);
  assign seq_if.state_o       = state_q;
  assign seq_if.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer. Stimulus pushes the expected state
// transitions (state, cycle relative to reset release, lock-loss count); a
// monitor pops and compares one entry every time state_o changes.
module tb_pll_reset_sequencer;

  localparam logic [2:0] ST_R = 3'd0;
  localparam logic [2:0] ST_W = 3'd1;
  localparam logic [2:0] ST_S = 3'd2;
  localparam logic [2:0] ST_U = 3'd3;  // RUN
  localparam logic [2:0] ST_F = 3'd4;

  logic refclk;
  logic rst;
  pll_reset_sequencer_if sif();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .seq_if (sif.master)
  );

  typedef struct {
    logic [2:0] st;
    int         cyc;
    logic [7:0] llc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Free-running cycle count; cycle numbers are taken relative to t0.
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc - t0);
    end
  endtask

  task automatic push(input logic [2:0] st, input int c, input logic [7:0] l);
    exp_t e;
    e.st  = st;
    e.cyc = c;
    e.llc = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int rel);
    while ((cyc - t0) < rel) @(negedge refclk);
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d pending required=0 pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"},     32'(sif.state_o), 0);
    check({name, "_pll_rst"},   32'(sif.pll_rst), 1);
    check({name, "_sys_rst_n"}, 32'(sif.sys_rst_n), 0);
    check({name, "_ready"},     32'(sif.ready), 0);
    check({name, "_fault"},     32'(sif.fault), 0);
    check({name, "_llc"},       32'(sif.lock_loss_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst            = 1'b0;
    sif.pll_locked = 1'b0;
    sif.relock_req = 1'b0;
    repeat (2) @(negedge refclk);
    check_reset_outputs("reset");
    rst = 1'b1;
    t0  = cyc;
  endtask

  task automatic pulse_relock(input int at);
    wait_until(at);
    sif.relock_req = 1'b1;
    wait_until(at + 1);
    sif.relock_req = 1'b0;
  endtask

  // Monitor: one scoreboard entry per observed state change.
  initial begin
    logic [2:0] prev;
    exp_t       e;
    prev = ST_R;
    forever begin
      @(negedge refclk);
      if (rst && sif.state_o != prev) begin
        $display("tr cycle=%0d state=%0d llc=%0d", cyc - t0, sif.state_o, sif.lock_loss_cnt);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition actual=state %0d at cycle %0d required=no transition",
                   sif.state_o, cyc - t0);
        end else begin
          e = exp_q.pop_front();
          check("tr_state",     32'(sif.state_o), 32'(e.st));
          check("tr_cycle",     cyc - t0, e.cyc);
          check("tr_llc",       32'(sif.lock_loss_cnt), 32'(e.llc));
          check("tr_pll_rst",   32'(sif.pll_rst), 32'(e.st == ST_R));
          check("tr_sys_rst_n", 32'(sif.sys_rst_n), 32'(e.st == ST_U));
          check("tr_ready",     32'(sif.ready), 32'(e.st == ST_U));
          check("tr_fault",     32'(sif.fault), 32'(e.st == ST_F));
        end
      end
      prev = sif.state_o;
    end
  end

  initial begin
    int t_run;
    int d;
    int tr;
    logic [7:0] llc;

    rst            = 1'b0;
    sif.pll_locked = 1'b0;
    sif.relock_req = 1'b0;

    // Nominal bring-up: lock at 10, lk at 12, STABILIZE 13, RUN 21.
    do_reset();
    push(ST_W, 4, 0);
    push(ST_S, 13, 0);
    push(ST_U, 21, 0);
    wait_until(3);
    check("nominal_pll_rst_c3", 32'(sif.pll_rst), 1);
    wait_until(10);
    sif.pll_locked = 1'b1;
    wait_until(30);
    check("nominal_ready", 32'(sif.ready), 1);
    drain("nominal");

    // Loss of lock in RUN, repeated until lock_loss_cnt saturates.
    t_run = 21;
    for (int k = 1; k <= 300; k++) begin
      d   = t_run + ((k == 1) ? 100 : 20);
      llc = (k > 255) ? 8'd255 : 8'(k);
      push(ST_R, d + 3, llc);
      push(ST_W, d + 7, llc);
      push(ST_S, d + 12, llc);
      push(ST_U, d + 20, llc);
      wait_until(d);
      sif.pll_locked = 1'b0;
      if (k == 1) begin
        wait_until(d + 2);
        check("loss_sys_rst_n_c2", 32'(sif.sys_rst_n), 1);
        wait_until(d + 3);
        check("loss_sys_rst_n_c3", 32'(sif.sys_rst_n), 0);
      end
      wait_until(d + 9);
      sif.pll_locked = 1'b1;
      wait_until(d + 21);
      drain("loss");
      t_run = d + 20;
    end
    check("llc_saturated", 32'(sif.lock_loss_cnt), 255);

    // relock_req in RUN: RESET_PLL next cycle, count unchanged.
    tr = t_run + 10;
    push(ST_R, tr + 1, 255);
    push(ST_W, tr + 5, 255);
    push(ST_S, tr + 6, 255);
    pulse_relock(tr);
    wait_until(tr + 8);
    drain("relock_run");

    // Asynchronous reset mid-STABILIZE, checked before the next clock edge.
    @(posedge refclk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async");

    // Lock glitch during STABILIZE.
    do_reset();
    push(ST_W, 4, 0);
    push(ST_S, 13, 0);
    push(ST_W, 18, 0);
    push(ST_S, 19, 0);
    push(ST_U, 27, 0);
    wait_until(10);
    sif.pll_locked = 1'b1;
    wait_until(15);
    sif.pll_locked = 1'b0;
    wait_until(16);
    sif.pll_locked = 1'b1;
    wait_until(26);
    check("glitch_sys_rst_n_c26", 32'(sif.sys_rst_n), 0);
    wait_until(27);
    check("glitch_sys_rst_n_c27", 32'(sif.sys_rst_n), 1);
    wait_until(30);
    drain("glitch");

    // Lock arriving at the timeout wins; loss at stabilize terminal wins.
    do_reset();
    push(ST_W, 4, 0);
    push(ST_S, 36, 0);
    push(ST_W, 44, 0);
    push(ST_S, 45, 0);
    push(ST_U, 53, 0);
    wait_until(33);
    sif.pll_locked = 1'b1;
    wait_until(41);
    sif.pll_locked = 1'b0;
    wait_until(42);
    sif.pll_locked = 1'b1;
    wait_until(60);
    drain("simultaneous");

    // Timeouts with no lock: initial pulse + 2 retries, then FAULT.
    do_reset();
    push(ST_W, 4, 0);
    push(ST_R, 36, 0);
    push(ST_W, 40, 0);
    push(ST_R, 72, 0);
    push(ST_W, 76, 0);
    push(ST_F, 108, 0);
    wait_until(300);
    check("fault_fault",     32'(sif.fault), 1);
    check("fault_pll_rst",   32'(sif.pll_rst), 0);
    check("fault_sys_rst_n", 32'(sif.sys_rst_n), 0);
    drain("timeout");

    // relock_req out of FAULT; the full retry budget is available again.
    push(ST_R, 301, 0);
    push(ST_W, 305, 0);
    push(ST_R, 337, 0);
    push(ST_W, 341, 0);
    push(ST_R, 373, 0);
    push(ST_W, 377, 0);
    push(ST_F, 409, 0);
    pulse_relock(300);
    wait_until(415);
    check("refault_fault", 32'(sif.fault), 1);
    drain("relock_fault");

    // relock_req inside RESET_PLL restarts the full reset pulse.
    push(ST_R, 421, 0);
    push(ST_W, 428, 0);
    pulse_relock(420);
    pulse_relock(423);
    wait_until(427);
    check("restart_pll_rst_c427", 32'(sif.pll_rst), 1);
    wait_until(430);
    drain("relock_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
